// File: rtl/sudoku_check_seq.sv
// sudoku_check_seq
//   Verifies a Sudoku board held in an external RAM. On start it walks the 27
//   groups (rows 0-8, columns 9-17, boxes 18-26), reading one cell per cycle.
//   Each cell is checked for empty, out-of-range or repeated values. The pass
//   stops at the first failing group and reports solved or err_* to main_FSM.
//
// Ports
//   clka       in   system clock, rising edge
//   restart_n  in   synchronous active-low reset
//   start      in   check request, sampled in IDLE only
//   rd_en      out  RAM read enable
//   rd_addr    out  RAM read address (row*GRID + col), held while rd_en=0
//   rd_data    in   RAM data, valid the cycle after rd_en
//   busy       out  high in SCAN, EVAL and DONE
//   done       out  one-cycle pulse at the end of a pass
//   solved     out  all groups passed (held until next start)
//   err_valid  out  pass failed (held until next start)
//   err_group  out  failing group index
//   err_code   out  00 none, 01 empty, 10 duplicate, 11 value>GRID
//   err_addr   out  address of the first offending cell
//   state      out  FSM state
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// SCAN  | issuing the GRID reads of group g
// EVAL  | last read of the group is checked, decide next group or DONE
// DONE  | one-cycle done pulse, results already valid
module sudoku_check_seq #(
    parameter int GRID   = 9,
    parameter int BOX    = 3,
    parameter int ADDR_W = 7,
    parameter int VAL_W  = 4
) (
    input  logic              clka,
    input  logic              restart_n,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [VAL_W-1:0]  rd_data,
    output logic              busy,
    output logic              done,
    output logic              solved,
    output logic              err_valid,
    output logic [4:0]        err_group,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] err_addr,
    output logic [1:0]        state
);

    localparam int KW  = $clog2(GRID);
    localparam int KCW = $clog2(BOX);
    localparam logic [4:0] G_COL  = 5'(GRID);
    localparam logic [4:0] G_BOX  = 5'(2 * GRID);
    localparam logic [4:0] G_LAST = 5'(3 * GRID - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        EVAL = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t cur, nxt;

    logic [4:0]        g;
    logic [KW-1:0]     k;
    logic [KCW-1:0]    kc;      // k mod BOX, column step inside a box
    logic [KCW-1:0]    bc;      // box index mod BOX
    logic [ADDR_W-1:0] addr;
    logic [GRID-1:0]   mask;
    logic              chk_valid;
    logic [ADDR_W-1:0] chk_addr;
    logic              flt;
    logic [1:0]        flt_code;
    logic [ADDR_W-1:0] flt_addr;

    logic [1:0]        cur_code;
    logic [GRID-1:0]   vbit;
    logic              group_fault;
    logic [ADDR_W-1:0] step_addr;
    logic [ADDR_W-1:0] next_base;

    // ---------------- cell check on the returning read data ----------------
    assign vbit = GRID'(1) << (rd_data - VAL_W'(1));

    always_comb begin
        cur_code = 2'b00;
        if (chk_valid) begin
            if (rd_data == '0)
                cur_code = 2'b01;
            else if (rd_data > VAL_W'(GRID))
                cur_code = 2'b11;
            else if ((mask & vbit) != '0)
                cur_code = 2'b10;
        end
    end

    assign group_fault = flt | (cur_code != 2'b00);

    // ---------------- address walk without dividers ----------------
    // Within a group: rows step by 1, columns by GRID, boxes by 1 except at
    // the end of a box row where they jump down to the next board row.
    always_comb begin
        if (g < G_COL)
            step_addr = addr + ADDR_W'(1);
        else if (g < G_BOX)
            step_addr = addr + ADDR_W'(GRID);
        else if (kc == KCW'(BOX - 1))
            step_addr = addr + ADDR_W'(GRID - BOX + 1);
        else
            step_addr = addr + ADDR_W'(1);
    end

    // Start address of group g+1, derived from addr(g, GRID-1).
    always_comb begin
        if (g == G_COL - 5'd1 || g == G_BOX - 5'd1)
            next_base = '0;
        else if (g < G_COL)
            next_base = addr + ADDR_W'(1);
        else if (g < G_BOX)
            next_base = addr - ADDR_W'(GRID * (GRID - 1) - 1);
        else if (bc == KCW'(BOX - 1))
            next_base = addr + ADDR_W'(1);
        else
            next_base = addr - ADDR_W'(GRID * (BOX - 1) - 1);
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clka) begin
        if (!restart_n)
            cur <= IDLE;
        else
            cur <= nxt;
    end

    always_comb begin
        nxt   = cur;
        rd_en = 1'b0;
        busy  = 1'b1;
        done  = 1'b0;
        case (cur)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    nxt = SCAN;
            end
            SCAN: begin
                rd_en = 1'b1;
                if (k == KW'(GRID - 1))
                    nxt = EVAL;
            end
            EVAL: begin
                if (group_fault || g == G_LAST)
                    nxt = DONE;
                else
                    nxt = SCAN;
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    assign rd_addr = addr;
    assign state   = cur;

    // ---------------- datapath ----------------
    always_ff @(posedge clka) begin
        if (!restart_n) begin
            g         <= '0;
            k         <= '0;
            kc        <= '0;
            bc        <= '0;
            addr      <= '0;
            mask      <= '0;
            chk_valid <= 1'b0;
            chk_addr  <= '0;
            flt       <= 1'b0;
            flt_code  <= '0;
            flt_addr  <= '0;
            solved    <= 1'b0;
            err_valid <= 1'b0;
            err_group <= '0;
            err_code  <= '0;
            err_addr  <= '0;
        end else begin
            chk_valid <= rd_en;
            chk_addr  <= addr;

            if (chk_valid) begin
                if (cur_code == 2'b00) begin
                    mask <= mask | vbit;
                end else if (!flt) begin
                    flt      <= 1'b1;
                    flt_code <= cur_code;
                    flt_addr <= chk_addr;
                end
            end

            case (cur)
                IDLE: begin
                    if (start) begin
                        g         <= '0;
                        k         <= '0;
                        kc        <= '0;
                        bc        <= '0;
                        addr      <= '0;
                        mask      <= '0;
                        flt       <= 1'b0;
                        solved    <= 1'b0;
                        err_valid <= 1'b0;
                        err_group <= '0;
                        err_code  <= '0;
                        err_addr  <= '0;
                    end
                end
                SCAN: begin
                    k  <= k + KW'(1);
                    kc <= (kc == KCW'(BOX - 1)) ? '0 : kc + KCW'(1);
                    // addr keeps addr(g, GRID-1) through EVAL
                    if (k != KW'(GRID - 1))
                        addr <= step_addr;
                end
                EVAL: begin
                    if (group_fault) begin
                        err_valid <= 1'b1;
                        err_group <= g;
                        err_code  <= flt ? flt_code : cur_code;
                        err_addr  <= flt ? flt_addr : chk_addr;
                    end else if (g == G_LAST) begin
                        solved <= 1'b1;
                    end else begin
                        if (g >= G_BOX)
                            bc <= (bc == KCW'(BOX - 1)) ? '0 : bc + KCW'(1);
                        g    <= g + 5'd1;
                        k    <= '0;
                        kc   <= '0;
                        mask <= '0;
                        flt  <= 1'b0;
                        addr <= next_base;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sudoku_check_seq.sv
module tb_sudoku_check_seq;

    logic       clka = 1'b0;
    logic       restart_n;
    logic       start;
    logic       rd_en;
    logic [6:0] rd_addr;
    logic [3:0] rd_data;
    logic       busy, done, solved, err_valid;
    logic [4:0] err_group;
    logic [1:0] err_code;
    logic [6:0] err_addr;
    logic [1:0] state;

    sudoku_check_seq dut (
        .clka(clka), .restart_n(restart_n), .start(start),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .solved(solved), .err_valid(err_valid),
        .err_group(err_group), .err_code(err_code), .err_addr(err_addr),
        .state(state)
    );

    always #5 clka = ~clka;

    logic [3:0] board [0:80];

    always @(posedge clka)
        if (rd_en) rd_data <= board[rd_addr];

    int cyc = 0;
    always @(posedge clka) cyc++;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit         solved;
        bit         errv;
        logic [4:0] grp;
        logic [1:0] code;
        logic [6:0] addr;
        int         edges;
        int         reads;
        bit         chk18;
    } exp_t;

    exp_t sb[$];

    // ---------------- monitor / scoreboard ----------------
    int         start_cyc = 0;
    int         reads = 0;
    bit         busy_q = 0;
    logic [6:0] g18 [0:8];
    int         g18_exp [0:8] = '{0, 1, 2, 9, 10, 11, 18, 19, 20};

    always @(negedge clka) begin
        exp_t e;
        if (busy && !busy_q) begin
            start_cyc = cyc;
            reads = 0;
        end
        busy_q = busy;
        if (rd_en) begin
            if (reads >= 162 && reads < 171) g18[reads-162] = rd_addr;
            reads++;
        end
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("done_edge", cyc - start_cyc, e.edges);
                chk("read_count", reads, e.reads);
                chk("solved", solved, e.solved);
                chk("err_valid", err_valid, e.errv);
                chk("err_group", err_group, e.grp);
                chk("err_code", err_code, e.code);
                chk("err_addr", err_addr, e.addr);
                if (e.chk18)
                    for (int i = 0; i < 9; i++)
                        chk($sformatf("g18_addr[%0d]", i), g18[i], g18_exp[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic load_valid();
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                board[r*9+c] = 4'(((3*r + r/3 + c) % 9) + 1);
    endtask

    task automatic pulse_start();
        @(negedge clka) start = 1'b1;
        @(negedge clka) start = 1'b0;
    endtask

    task automatic run_pass(input exp_t e);
        bit seen;
        sb.push_back(e);
        pulse_start();
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (done) seen = 1;
            else @(negedge clka);
        end
        if (!seen) chk("done_timeout", 0, 1);
        @(negedge clka);
        @(negedge clka);
    endtask

    function automatic exp_t mk(bit s, bit ev, int grp, int code, int addr,
                                int edges, int rds, bit c18);
        exp_t e;
        e.solved = s; e.errv = ev; e.grp = 5'(grp); e.code = 2'(code);
        e.addr = 7'(addr); e.edges = edges; e.reads = rds; e.chk18 = c18;
        return e;
    endfunction

    initial begin
        load_valid();
        restart_n = 1'b0;
        start     = 1'b1;
        @(posedge clka);
        @(posedge clka);
        @(negedge clka);
        chk("rst_state", state, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_solved", solved, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_err_group", err_group, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_err_addr", err_addr, 0);
        restart_n = 1'b1;
        start     = 1'b0;
        @(negedge clka);

        // valid board
        run_pass(mk(1, 0, 0, 0, 0, 270, 243, 1));

        // empty cell in row 4
        load_valid();
        board[40] = 4'd0;
        run_pass(mk(0, 1, 4, 1, 40, 50, 45, 0));

        // swap cells 0 and 1: rows still pass, column 0 repeats at row 3
        load_valid();
        board[0] = 4'd2;
        board[1] = 4'd1;
        run_pass(mk(0, 1, 9, 2, 27, 100, 90, 0));

        // out-of-range value in the very last cell of row 8
        load_valid();
        board[80] = 4'd12;
        run_pass(mk(0, 1, 8, 3, 80, 90, 81, 0));

        // abort: re-start ignored mid-scan, then reset during group 5
        load_valid();
        pulse_start();
        repeat (32) @(negedge clka);
        start = 1'b1;
        @(negedge clka);
        start = 1'b0;
        chk("restart_ignored_state", state, 1);
        chk("restart_ignored_addr", rd_addr, 30);
        repeat (19) @(negedge clka);
        restart_n = 1'b0;
        @(negedge clka);
        chk("abort_state", state, 0);
        chk("abort_rd_en", rd_en, 0);
        chk("abort_busy", busy, 0);
        restart_n = 1'b1;
        @(negedge clka);

        run_pass(mk(1, 0, 0, 0, 0, 270, 243, 1));

        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
